// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receive pins plus the byte-queue read side shared with the 68k bus interface.
interface ps2_rx_fifo_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       pop;
    logic       err_clr;
    logic [7:0] read_reg;
    logic       rx_valid;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, pop, err_clr,
        input  read_reg, rx_valid, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, pop, err_clr,
        output read_reg, rx_valid, overflow, frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a small byte FIFO with sticky
// overflow and framing-error flags.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input logic         clk,
    input logic         rst,
    ps2_rx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic             ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic             ps2_data_p0, ps2_data_p1;
    logic             pop_q;
    logic             fall, pop_edge;
    state_t           state;
    logic [2:0]       bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       shreg;
    logic             parity_bit;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full, good, stop_fall, push_req, do_push, do_pop;
    logic             tmo_hit, timeout, ovf_set, ferr_set;
    logic             overflow, frame_err;

    // Stage p0/p1: synchronise the pins; p2 holds the previous clock level
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
            pop_q       <= 1'b0;
        end else begin
            ps2_clk_p0  <= bus.ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= bus.ps2_data;
            ps2_data_p1 <= ps2_data_p0;
            pop_q       <= bus.pop;
        end
    end

    assign fall      = ps2_clk_p2 & ~ps2_clk_p1;
    assign pop_edge  = bus.pop & ~pop_q;
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = (state != IDLE) && !fall && tmo_hit;
    assign stop_fall = (state == STOP) && fall;
    assign good      = ps2_data_p1 & (^{shreg, parity_bit});
    assign push_req  = stop_fall & good;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop    = pop_edge && (count != '0);
    // A pop in the same cycle frees a slot, so a push into a full queue still lands
    assign do_push   = push_req && (!full || do_pop);
    assign ovf_set   = push_req && full && !do_pop;
    assign ferr_set  = ((state == IDLE) && fall && ps2_data_p1) ||
                       (stop_fall && !good) || timeout;

    // Frame sequencer with mid-frame watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
            if (fall && !ps2_data_p1) begin
                state   <= DATA;
                bit_cnt <= '0;
            end
        end else if (!fall) begin
            if (tmo_hit) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end else begin
            tmo_cnt <= '0;
            case (state)
                DATA: begin
                    if (bit_cnt == 3'd7) state <= PARITY;
                    else                 bit_cnt <= bit_cnt + 3'd1;
                end
                PARITY:  state <= STOP;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fall && state == DATA)   shreg      <= {ps2_data_p1, shreg[7:1]};
        if (fall && state == PARITY) parity_bit <= ps2_data_p1;
        if (do_push)                 mem[wr_ptr] <= shreg;
    end

    // Queue bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= ovf_set  | (overflow  & ~bus.err_clr);
            frame_err <= ferr_set | (frame_err & ~bus.err_clr);
        end
    end

    assign bus.read_reg  = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.rx_valid  = (count != '0);
    assign bus.overflow  = overflow;
    assign bus.frame_err = frame_err;
endmodule
